// File: rtl/r_issue_unit.sv
// -----------------------------------------------------------------------------
// r_issue_unit
// Front end of a 4-stage R-type datapath. It buffers 32-bit MIPS instruction
// words in a small FIFO and decodes the FIFO head into datapath control fields.
// It issues at most one instruction per cycle. The datapath has no forwarding,
// so the unit holds back a read-after-write consumer until its producer is
// three issue slots old, and sends bubbles in the meantime.
//
// Optional feature: define ISSUE_STATS_EN to add the issued_cnt / stall_cnt
// statistics outputs.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst_n        in   1   synchronous reset, active low
//   instr        in   32  instruction word
//   instr_valid  in   1   instr present
//   instr_ready  out  1   FIFO can accept (transfer on valid & ready)
//   rs1/rs2/rd   out  5   register specifiers of the issued slot
//   we           out  1   regfile write enable for the issued slot
//   ALUop        out  2   00 add, 01 sub, 10 R-type (use func)
//   func         out  6   function field of the issued slot
//   stall        out  1   bubble issued this cycle because of a hazard
//   illegal      out  1   one-cycle pulse: unsupported opcode dropped
//   issued_cnt   out  32  (ISSUE_STATS_EN) real instructions issued
//   stall_cnt    out  32  (ISSUE_STATS_EN) hazard bubbles issued
// -----------------------------------------------------------------------------
module r_issue_unit #(
  parameter int DEPTH     = 4,
  parameter int HAZ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        we,
  output logic [1:0]  ALUop,
  output logic [5:0]  func,
  output logic        stall,
  output logic        illegal
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0] issued_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  logic [31:0]          mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic [HAZ_DEPTH-1:0] sb_vld_q;
  logic [4:0]           sb_rd_q [HAZ_DEPTH];

  logic [4:0] rs1_q, rs2_q, rd_q, rs1_d, rs2_d, rd_d;
  logic [5:0] func_q, func_d;
  logic [1:0] alu_q, alu_d;
  logic       we_q, we_d, stall_q, stall_d, ill_q, ill_d;

  logic [31:0] head_s;
  logic        empty_s, push_s, pop_s, hazard_s, issue_s;
  logic        unused_shamt_s;

  assign instr_ready    = rst_n & (count_q < CW'(DEPTH));
  assign push_s         = instr_valid & instr_ready;
  assign empty_s        = (count_q == CW'(0));
  assign head_s         = mem_q[rd_ptr_q];
  assign unused_shamt_s = ^head_s[10:6];

  // Compare the head's source registers against every in-flight write.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_vld_q[i] && ((sb_rd_q[i] == head_s[25:21]) || (sb_rd_q[i] == head_s[20:16]))) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // Issue decision for the FIFO head. The illegal check comes first, so an
  // illegal head never stalls.
  always_comb begin
    rs1_d   = 5'd0;
    rs2_d   = 5'd0;
    rd_d    = 5'd0;
    func_d  = 6'd0;
    alu_d   = 2'b00;
    we_d    = 1'b0;
    stall_d = 1'b0;
    ill_d   = 1'b0;
    pop_s   = 1'b0;
    issue_s = 1'b0;
    if (empty_s) begin
      pop_s = 1'b0;
    end else begin
      case (head_s[31:26])
        OP_RTYPE, OP_BEQ: begin
          if (hazard_s) begin
            stall_d = 1'b1;
          end else begin
            pop_s   = 1'b1;
            issue_s = 1'b1;
            rs1_d   = head_s[25:21];
            rs2_d   = head_s[20:16];
            if (head_s[31:26] == OP_RTYPE) begin
              rd_d   = head_s[15:11];
              func_d = head_s[5:0];
              alu_d  = 2'b10;
              we_d   = 1'b1;
            end else begin
              alu_d  = 2'b01;
            end
          end
        end
        default: begin
          pop_s = 1'b1;
          ill_d = 1'b1;
        end
      endcase
    end
  end

  // FIFO storage: data only, validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= instr;
    end
  end

  // FIFO pointers, hazard scoreboard and registered issue outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sb_vld_q <= '0;
      for (int i = 0; i < HAZ_DEPTH; i++) sb_rd_q[i] <= 5'd0;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      rd_q     <= 5'd0;
      func_q   <= 6'd0;
      alu_q    <= 2'b00;
      we_q     <= 1'b0;
      stall_q  <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // Slot 0 holds the write issued this cycle; bubbles load valid=0.
      for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
        sb_vld_q[i] <= sb_vld_q[i-1];
        sb_rd_q[i]  <= sb_rd_q[i-1];
      end
      sb_vld_q[0] <= we_d;
      sb_rd_q[0]  <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      func_q  <= func_d;
      alu_q   <= alu_d;
      we_q    <= we_d;
      stall_q <= stall_d;
      ill_q   <= ill_d;
    end
  end

  assign rs1     = rs1_q;
  assign rs2     = rs2_q;
  assign rd      = rd_q;
  assign func    = func_q;
  assign ALUop   = alu_q;
  assign we      = we_q;
  assign stall   = stall_q;
  assign illegal = ill_q;

`ifdef ISSUE_STATS_EN
  logic [31:0] issued_cnt_q, stall_cnt_q;

  // Statistics counters; both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued_cnt_q <= 32'd0;
      stall_cnt_q  <= 32'd0;
    end else begin
      if (issue_s) issued_cnt_q <= issued_cnt_q + 32'd1;
      if (stall_d) stall_cnt_q  <= stall_cnt_q + 32'd1;
    end
  end

  assign issued_cnt = issued_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`else
  logic unused_issue_s;
  assign unused_issue_s = issue_s;
`endif

endmodule

// File: tb/tb_r_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_r_issue_unit
// Cycle-by-cycle vector table for r_issue_unit. Each row gives the inputs for one
// clock edge and the outputs expected just after that edge:
// {we, ALUop, rs1, rs2, rd, func, stall, illegal, instr_ready}.
// -----------------------------------------------------------------------------
module tb_r_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  rs1, rs2, rd;
  logic        we, stall, illegal;
  logic [1:0]  ALUop;
  logic [5:0]  func;
`ifdef ISSUE_STATS_EN
  logic [31:0] issued_cnt, stall_cnt;
`endif

  r_issue_unit dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rs1(rs1), .rs2(rs2), .rd(rd), .we(we),
    .ALUop(ALUop), .func(func), .stall(stall), .illegal(illegal)
`ifdef ISSUE_STATS_EN
    , .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          vld;
    logic [31:0] ins;
    logic [26:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  localparam logic [31:0] W_ADD  = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] W_AND  = 32'h0085_3024; // and $6,$4,$5
  localparam logic [31:0] W_SUB  = 32'h0061_2022; // sub $4,$3,$1
  localparam logic [31:0] W_C2   = 32'h0082_2820; // add $5,$4,$2
  localparam logic [31:0] W_C3   = 32'h00A2_3020; // add $6,$5,$2
  localparam logic [31:0] W_C4   = 32'h00C2_3820; // add $7,$6,$2
  localparam logic [31:0] W_C5   = 32'h00E2_4020; // add $8,$7,$2
  localparam logic [31:0] W_C6   = 32'h0102_4820; // add $9,$8,$2
  localparam logic [31:0] W_LW   = 32'h8C22_0000; // lw $2,0($1)
  localparam logic [31:0] W_LW3  = 32'h8C62_0000; // lw $2,0($3)
  localparam logic [31:0] W_ADD7 = 32'h0022_3820; // add $7,$1,$2
  localparam logic [31:0] W_BEQ  = 32'h1067_0005; // beq $3,$7,5
  localparam logic [31:0] W_X    = 32'hFFFF_FFFF; // don't-care word when idle

  function automatic logic [26:0] e_bub(input bit st, input bit il, input bit rdy);
    return {1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 6'd0, st, il, rdy};
  endfunction

  function automatic logic [26:0] e_r(input logic [31:0] w, input bit rdy);
    return {1'b1, 2'b10, w[25:21], w[20:16], w[15:11], w[5:0], 1'b0, 1'b0, rdy};
  endfunction

  function automatic logic [26:0] e_beq(input logic [31:0] w, input bit rdy);
    return {1'b0, 2'b01, w[25:21], w[20:16], 5'd0, 6'd0, 1'b0, 1'b0, rdy};
  endfunction

  task automatic add_row(input bit rst, input bit vld, input logic [31:0] ins,
                         input logic [26:0] exp);
    tbl.push_back('{rst, vld, ins, exp});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) add_row(1'b0, 1'b0, W_X, e_bub(1'b0, 1'b0, 1'b1));
  endtask

  task automatic stl(input bit vld, input logic [31:0] ins, input bit rdy);
    add_row(1'b0, vld, ins, e_bub(1'b1, 1'b0, rdy));
  endtask

  initial begin
    logic [26:0] got;

    // Reset held two cycles with a valid word offered; nothing may issue after.
    add_row(1'b1, 1'b1, W_ADD, e_bub(1'b0, 1'b0, 1'b0));
    add_row(1'b1, 1'b1, W_ADD, e_bub(1'b0, 1'b0, 1'b0));
    idle(2);
    // Independent pair issues on consecutive cycles.
    add_row(1'b0, 1'b1, W_ADD, e_bub(1'b0, 1'b0, 1'b1));
    add_row(1'b0, 1'b1, W_AND, e_r(W_ADD, 1'b1));
    add_row(1'b0, 1'b0, W_X,   e_r(W_AND, 1'b1));
    idle(2);
    // Dependent pair: two stall bubbles, consumer at producer+3.
    add_row(1'b0, 1'b1, W_ADD, e_bub(1'b0, 1'b0, 1'b1));
    add_row(1'b0, 1'b1, W_SUB, e_r(W_ADD, 1'b1));
    stl(1'b0, W_X, 1'b1);
    stl(1'b0, W_X, 1'b1);
    add_row(1'b0, 1'b0, W_X,   e_r(W_SUB, 1'b1));
    idle(2);
    // Dependent chain fills the FIFO; ready drops at 4 entries, order kept.
    add_row(1'b0, 1'b1, W_ADD, e_bub(1'b0, 1'b0, 1'b1));
    add_row(1'b0, 1'b1, W_SUB, e_r(W_ADD, 1'b1));
    stl(1'b1, W_C2, 1'b1);
    stl(1'b1, W_C3, 1'b1);
    add_row(1'b0, 1'b1, W_C4,  e_r(W_SUB, 1'b1));
    stl(1'b1, W_C5, 1'b0);
    stl(1'b1, W_C6, 1'b0);                          // refused: full
    add_row(1'b0, 1'b1, W_C6,  e_r(W_C2, 1'b1));    // refused: full even with pop
    stl(1'b1, W_C6, 1'b0);                          // accepted
    stl(1'b0, W_X, 1'b0);
    add_row(1'b0, 1'b0, W_X,   e_r(W_C3, 1'b1));
    stl(1'b0, W_X, 1'b1);
    stl(1'b0, W_X, 1'b1);
    add_row(1'b0, 1'b0, W_X,   e_r(W_C4, 1'b1));
    stl(1'b0, W_X, 1'b1);
    stl(1'b0, W_X, 1'b1);
    add_row(1'b0, 1'b0, W_X,   e_r(W_C5, 1'b1));
    stl(1'b0, W_X, 1'b1);
    stl(1'b0, W_X, 1'b1);
    add_row(1'b0, 1'b0, W_X,   e_r(W_C6, 1'b1));
    idle(2);
    // Illegal opcode drops with a pulse; the next word issues the following cycle.
    // A second illegal word that reads a pending register must not stall.
    add_row(1'b0, 1'b1, W_LW,  e_bub(1'b0, 1'b0, 1'b1));
    add_row(1'b0, 1'b1, W_ADD, e_bub(1'b0, 1'b1, 1'b1));
    add_row(1'b0, 1'b1, W_LW3, e_r(W_ADD, 1'b1));
    add_row(1'b0, 1'b0, W_X,   e_bub(1'b0, 1'b1, 1'b1));
    idle(2);
    // Reset mid-stream discards queued words.
    add_row(1'b0, 1'b1, W_ADD, e_bub(1'b0, 1'b0, 1'b1));
    add_row(1'b0, 1'b1, W_SUB, e_r(W_ADD, 1'b1));
    stl(1'b1, W_AND, 1'b1);
    add_row(1'b1, 1'b1, W_AND, e_bub(1'b0, 1'b0, 1'b0));
    add_row(1'b1, 1'b1, W_AND, e_bub(1'b0, 1'b0, 1'b0));
    idle(2);
    // beq whose rs2 depends on the preceding add.
    add_row(1'b0, 1'b1, W_ADD7, e_bub(1'b0, 1'b0, 1'b1));
    add_row(1'b0, 1'b1, W_BEQ,  e_r(W_ADD7, 1'b1));
    stl(1'b0, W_X, 1'b1);
    stl(1'b0, W_X, 1'b1);
    add_row(1'b0, 1'b0, W_X,    e_beq(W_BEQ, 1'b1));
    idle(2);

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    foreach (tbl[i]) begin
      rst_n       = !tbl[i].rst;
      instr_valid = tbl[i].vld;
      instr       = tbl[i].ins;
      @(posedge clk);
      #1;
      got = {we, ALUop, rs1, rs2, rd, func, stall, illegal, instr_ready};
      n_chk++;
      if (got !== tbl[i].exp) begin
        n_fail++;
        $display("FAIL row%0d outputs got=%h exp=%h", i, got, tbl[i].exp);
      end
`ifdef ISSUE_STATS_EN
      if (tbl[i].rst) begin
        n_chk++;
        if ({issued_cnt, stall_cnt} !== 64'd0) begin
          n_fail++;
          $display("FAIL row%0d stats_reset got=%h exp=0", i, {issued_cnt, stall_cnt});
        end
      end
`endif
    end

`ifdef ISSUE_STATS_EN
    n_chk++;
    if (issued_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL issued_cnt got=%0d exp=2", issued_cnt);
    end
    n_chk++;
    if (stall_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL stall_cnt got=%0d exp=2", stall_cnt);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
